// File: rtl/mem_responder.sv
// Backing-store memory and responder for the cache memory-side port: block reads as 4-beat bursts, masked writes.
// Optional MEM_RESP_GAP_EN inserts one idle cycle between read beats; default build emits back-to-back beats.
module mem_responder #(
  parameter int ADDR_BITS      = 28,
  parameter int MEM_DEPTH_LOG2 = 12,
  parameter int READ_LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_req_valid,
  output logic                 mem_req_ready,
  input  logic [ADDR_BITS-1:0] mem_req_addr,
  input  logic                 mem_req_rw,
  input  logic                 mem_req_data_valid,
  output logic                 mem_req_data_ready,
  input  logic [127:0]         mem_req_data_bits,
  input  logic [15:0]          mem_req_data_mask,
  output logic                 mem_resp_valid,
  output logic [127:0]         mem_resp_data
);

  localparam int LAT_W = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_RD_LAT, S_RD_BURST, S_WR_DATA} state_t;

  logic [127:0] mem [0:(1<<MEM_DEPTH_LOG2)-1];

  state_t                    r_state;
  state_t                    w_next;
  logic [LAT_W-1:0]          r_lat;
  logic [1:0]                r_beat;
  logic [MEM_DEPTH_LOG2-1:2] r_blk;
  logic [MEM_DEPTH_LOG2-1:0] r_widx;
  logic                      r_req_ready;
  logic                      r_data_ready;
  logic                      r_resp_valid;
  logic [127:0]              r_resp_data;

  logic                      w_req_fire;
  logic                      w_dat_fire;
  logic                      w_emit;
  logic                      w_gap_hold;
  logic [MEM_DEPTH_LOG2-1:2] w_blk;
  logic [MEM_DEPTH_LOG2-1:0] w_ridx;
  logic                      w_unused;

  assign w_req_fire = mem_req_valid & r_req_ready;
  assign w_dat_fire = mem_req_data_valid & r_data_ready;
  assign w_unused   = ^mem_req_addr[ADDR_BITS-1:MEM_DEPTH_LOG2];

  // With READ_LATENCY==1 the first beat is fetched on the accepting edge, so take the block from the port.
  assign w_blk  = (r_state == S_IDLE) ? mem_req_addr[MEM_DEPTH_LOG2-1:2] : r_blk;
  assign w_ridx = {w_blk, r_beat};

`ifdef MEM_RESP_GAP_EN
  logic r_gap;
  assign w_gap_hold = r_gap;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_gap <= 1'b0;
    else        r_gap <= w_emit;
  end
`else
  assign w_gap_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_fire) begin
          if (mem_req_rw)             w_next = S_WR_DATA;
          else if (READ_LATENCY == 1) w_next = S_RD_BURST;
          else                        w_next = S_RD_LAT;
        end
      end
      S_RD_LAT:   if (r_lat == '0) w_next = S_RD_BURST;
      // r_beat has wrapped back to 0 only once all four beats are out.
      S_RD_BURST: if (r_beat == 2'd0) w_next = S_IDLE;
      S_WR_DATA:  if (w_dat_fire) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    w_emit = (w_next == S_RD_BURST) && !w_gap_hold;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lat        <= '0;
      r_beat       <= 2'd0;
      r_blk        <= '0;
      r_widx       <= '0;
      r_req_ready  <= 1'b0;
      r_data_ready <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_req_ready  <= (w_next == S_IDLE);
      r_data_ready <= (w_next == S_WR_DATA);
      r_resp_valid <= w_emit;
      if (w_emit) begin
        r_resp_data <= mem[w_ridx];
        r_beat      <= r_beat + 2'd1;
      end
      if (r_state == S_IDLE && w_req_fire) begin
        r_blk  <= mem_req_addr[MEM_DEPTH_LOG2-1:2];
        r_widx <= mem_req_addr[MEM_DEPTH_LOG2-1:0];
        r_lat  <= LAT_W'(READ_LATENCY - 2);
      end else if (r_state == S_RD_LAT) begin
        r_lat <= r_lat - LAT_W'(1);
      end
    end
  end

  // Array has no reset; r_state is forced to IDLE during reset, so no write slips through.
  always_ff @(posedge clk) begin
    if (r_state == S_WR_DATA && w_dat_fire) begin
      for (int i = 0; i < 16; i++) begin
        if (mem_req_data_mask[i]) mem[r_widx][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
      end
    end
  end

  assign mem_req_ready      = r_req_ready;
  assign mem_req_data_ready = r_data_ready;
  assign mem_resp_valid     = r_resp_valid;
  assign mem_resp_data      = r_resp_data;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: table of read/write operations plus reset sequences.
module tb_mem_responder;

  localparam int L = 4;
`ifdef MEM_RESP_GAP_EN
  localparam int STRIDE  = 2;
  localparam int RDY_CYC = L + 7;
`else
  localparam int STRIDE  = 1;
  localparam int RDY_CYC = L + 4;
`endif

  localparam logic [127:0] A0  = {16{8'hA0}};
  localparam logic [127:0] A1  = {16{8'hA1}};
  localparam logic [127:0] A2  = {16{8'hA2}};
  localparam logic [127:0] A3  = {16{8'hA3}};
  localparam logic [127:0] W10 = {16{8'h11}};
  localparam logic [127:0] B11 = {16{8'hB1}};
  localparam logic [127:0] B12 = {16{8'hB2}};
  localparam logic [127:0] B13 = {16{8'hB3}};
  localparam logic [127:0] N10 = 128'h11111111_11111111_11111111_FFFFFFFF;
  localparam logic [127:0] M41 = 128'h0FA1A1A1_A1A1A1A1_A1A1A1A1_A1A1A100;
  localparam logic [127:0] D41 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] S11 = {16{8'h5A}};

  logic         clk;
  logic         reset;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [27:0]  mem_req_addr;
  logic         mem_req_rw;
  logic         mem_req_data_valid;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  int n_tests = 0;
  int n_fail  = 0;

  mem_responder dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rw;
    logic [27:0]      addr;
    logic [127:0]     wdata;
    logic [15:0]      mask;
    int               delay;
    logic [127:0]     old;
    logic [3:0][127:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered and left at a negedge with the responder idle.
  task automatic do_read(input logic [27:0] a, input logic [3:0][127:0] exp);
    bit is_beat;
    int b;
    chk1($sformatf("rd%0h_ready_c0", a), mem_req_ready, 1'b1);
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = a;
    next_cyc();
    mem_req_valid = 1'b0;
    for (int c = 1; c <= RDY_CYC; c++) begin
      b       = (c - L) / STRIDE;
      is_beat = (c >= L) && ((c - L) % STRIDE == 0) && (b < 4);
      chk1($sformatf("rd%0h_valid_c%0d", a, c), mem_resp_valid, is_beat);
      if (is_beat) chk128($sformatf("rd%0h_beat%0d", a, b), mem_resp_data, exp[b]);
      chk1($sformatf("rd%0h_ready_c%0d", a, c), mem_req_ready, (c == RDY_CYC));
      if (c < RDY_CYC) next_cyc();
    end
  endtask

  task automatic do_write(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m,
                          input int delay, input logic [127:0] old);
    chk1($sformatf("wr%0h_ready_c0", a), mem_req_ready, 1'b1);
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b1;
    mem_req_addr  = a;
    next_cyc();
    mem_req_valid = 1'b0;
    for (int i = 0; i < delay; i++) begin
      chk1($sformatf("wr%0h_dready_c%0d", a, i + 1), mem_req_data_ready, 1'b1);
      chk1($sformatf("wr%0h_rready_c%0d", a, i + 1), mem_req_ready, 1'b0);
      chk1($sformatf("wr%0h_rvalid_c%0d", a, i + 1), mem_resp_valid, 1'b0);
      chk128($sformatf("wr%0h_hold_c%0d", a, i + 1), dut.mem[a[11:0]], old);
      // Stray read requests while waiting for data must be ignored.
      mem_req_valid = (i % 2 == 0);
      mem_req_rw    = 1'b0;
      mem_req_addr  = 28'h40;
      next_cyc();
    end
    mem_req_valid      = 1'b0;
    chk1($sformatf("wr%0h_dready_hs", a), mem_req_data_ready, 1'b1);
    mem_req_data_valid = 1'b1;
    mem_req_data_bits  = d;
    mem_req_data_mask  = m;
    next_cyc();
    mem_req_data_valid = 1'b0;
    chk1($sformatf("wr%0h_ready_after", a), mem_req_ready, 1'b1);
    chk1($sformatf("wr%0h_dready_after", a), mem_req_data_ready, 1'b0);
  endtask

  initial begin
    reset              = 1'b0;
    mem_req_valid      = 1'b0;
    mem_req_addr       = '0;
    mem_req_rw         = 1'b0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = '0;
    mem_req_data_mask  = '0;

    tbl[0] = '{rw:1'b0, addr:28'h42,    wdata:'0,          mask:16'h0,    delay:0, old:'0,  exp:{A3, A2, A1, A0}};
    tbl[1] = '{rw:1'b1, addr:28'h10,    wdata:{16{8'hFF}}, mask:16'h000F, delay:0, old:W10, exp:'0};
    tbl[2] = '{rw:1'b0, addr:28'h10,    wdata:'0,          mask:16'h0,    delay:0, old:'0,  exp:{B13, B12, B11, N10}};
    tbl[3] = '{rw:1'b1, addr:28'h41,    wdata:D41,         mask:16'h8001, delay:5, old:A1,  exp:'0};
    tbl[4] = '{rw:1'b0, addr:28'h43,    wdata:'0,          mask:16'h0,    delay:0, old:'0,  exp:{A3, A2, M41, A0}};
    tbl[5] = '{rw:1'b1, addr:28'h12,    wdata:{16{8'h77}}, mask:16'h0000, delay:1, old:B12, exp:'0};
    tbl[6] = '{rw:1'b1, addr:28'h1011,  wdata:S11,         mask:16'hFFFF, delay:0, old:B11, exp:'0};
    tbl[7] = '{rw:1'b0, addr:28'h13,    wdata:'0,          mask:16'h0,    delay:0, old:'0,  exp:{B13, B12, S11, N10}};

    dut.mem[12'h040] = A0;
    dut.mem[12'h041] = A1;
    dut.mem[12'h042] = A2;
    dut.mem[12'h043] = A3;
    dut.mem[12'h010] = W10;
    dut.mem[12'h011] = B11;
    dut.mem[12'h012] = B12;
    dut.mem[12'h013] = B13;

    next_cyc();
    next_cyc();
    chk1("rst_req_ready", mem_req_ready, 1'b0);
    chk1("rst_data_ready", mem_req_data_ready, 1'b0);
    chk1("rst_resp_valid", mem_resp_valid, 1'b0);
    chk128("rst_resp_data", mem_resp_data, '0);
    reset = 1'b1;
    #1;
    chk1("rel_ready_before_edge", mem_req_ready, 1'b0);
    next_cyc();
    chk1("rel_ready_after_edge", mem_req_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk1($sformatf("idle_resp_valid_%0d", i), mem_resp_valid, 1'b0);
      next_cyc();
    end

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rw) do_write(tbl[i].addr, tbl[i].wdata, tbl[i].mask, tbl[i].delay, tbl[i].old);
      else           do_read(tbl[i].addr, tbl[i].exp);
    end

    // Reset after beat 1 of a burst: remaining beats must be dropped.
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = 28'h40;
    next_cyc();
    mem_req_valid = 1'b0;
    for (int c = 1; c <= L + STRIDE; c++) begin
      if (c == L) chk128("mid_beat0", mem_resp_data, A0);
      if (c == L + STRIDE) begin
        chk1("mid_beat1_valid", mem_resp_valid, 1'b1);
        chk128("mid_beat1", mem_resp_data, M41);
      end else begin
        next_cyc();
      end
    end
    reset = 1'b0;
    #1;
    chk1("mid_rst_valid", mem_resp_valid, 1'b0);
    chk128("mid_rst_data", mem_resp_data, '0);
    chk1("mid_rst_ready", mem_req_ready, 1'b0);
    @(negedge clk);
    next_cyc();
    chk1("mid_rst_valid_held", mem_resp_valid, 1'b0);
    reset = 1'b1;
    next_cyc();
    chk1("mid_rel_ready", mem_req_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk1($sformatf("mid_no_beat_%0d", i), mem_resp_valid, 1'b0);
      next_cyc();
    end
    do_read(28'h40, {A3, A2, M41, A0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Backing-store memory model and responder for the cache memory-side request interface. It accepts block-read and masked single-beat write requests from the cache, services reads as an in-order 4-beat burst of 128-bit beats after a fixed latency, and commits writes byte-masked into an internal array. It sits between the cache and the testbench as the memory end of the protocol. It is used for simulation and for FPGA bring-up.

## Interface
- `ADDR_BITS`, default 28: width of `mem_req_addr`, a 128-bit beat address.
- `MEM_DEPTH_LOG2`, default 12: log2 of the array depth in 128-bit beats. Upper address bits are ignored, so addresses alias.
- `READ_LATENCY`, default 4: cycles from request acceptance to the first read beat. Must be at least 1.
- `clk`  input  1  clock; all flops are rising-edge.
- `reset`  input  1  asynchronous, active-low reset (0 = in reset).
- `mem_req_valid`  input  1  request valid.
- `mem_req_ready`  output  1  request accepted when `valid & ready` at a rising edge.
- `mem_req_addr`  input  ADDR_BITS  beat address of the request.
- `mem_req_rw`  input  1  request type: 0 = read, 1 = write.
- `mem_req_data_valid`  input  1  write data beat valid.
- `mem_req_data_ready`  output  1  write data beat accepted when `data_valid & data_ready`.
- `mem_req_data_bits`  input  128  write data.
- `mem_req_data_mask`  input  16  byte enables; bit i = 1 writes byte i (bits [8i+7:8i]).
- `mem_resp_valid`  output  1  read beat valid. There is no backpressure: the consumer must take every beat.
- `mem_resp_data`  output  128  read beat data.

## Operation
- Storage: register array `mem[0:2^MEM_DEPTH_LOG2-1]` of 128 bits. The array is not cleared by reset. The bench may preload it hierarchically.
- Index: `idx = addr[MEM_DEPTH_LOG2-1:0]`.
- FSM states:
  - IDLE: `mem_req_ready=1`.
    - Read accepted: latch `base = {addr[ADDR_BITS-1:2], 2'b00}`, go to RD_LAT.
    - Write accepted: latch `addr`, go to WR_DATA.
  - RD_LAT: latency counter runs; go to RD_BURST when it expires.
  - RD_BURST: emits beats in the order `base+0, +1, +2, +3`.
    - Bursts are always block-aligned. There is no critical-word-first and no wrap from the request offset.
    - A 2-bit beat counter drives the sequence. After beat 3 the FSM returns to IDLE.
  - WR_DATA: `mem_req_data_ready=1`. On data handshake, for each byte i with mask[i]=1, write `mem[idx]` byte i from `data_bits`. Masked-off bytes are unchanged. Return to IDLE.
- `mem_req_data_valid` outside WR_DATA is ignored.
- `mem_req_valid` outside IDLE is ignored; `ready` is 0.
- Requests are strictly one at a time; there is no queueing.
- A mask of all zeros completes the handshake with no array change.
- All outputs are registered.
- Reset (asynchronous assertion, at any time including mid-burst or mid-write):
  - State goes to IDLE. Counters clear.
  - `mem_req_ready=0`, `mem_req_data_ready=0`, `mem_resp_valid=0`, `mem_resp_data=0`.
  - Any in-flight burst is dropped, with no further beats.
  - A pending write is not performed.
  - Array contents are retained.

## Timing
- `mem_req_ready` rises at the first rising edge after `reset` goes high.
- Cycle 0 is the cycle in which the request handshake occurs.
- Read:
  - `mem_resp_valid=1` in cycles `READ_LATENCY` through `READ_LATENCY+3`, consecutive, with the beat data valid in the same cycle.
  - `mem_req_ready=1` again in cycle `READ_LATENCY+4`.
- Read data is sampled from the array when each beat is registered. A write completed before the read request is always visible.
- Write:
  - `mem_req_data_ready=1` from cycle 1 until the data handshake.
  - For a data handshake in cycle k, the array is updated at the end of cycle k and `mem_req_ready=1` in cycle k+1.
- Back-to-back requests: a new request may be accepted in the first IDLE cycle.

## Configuration
- `MEM_RESP_GAP_EN`
  - Defined: one idle cycle (`mem_resp_valid=0`) is inserted between consecutive read beats. Beats appear in cycles L, L+2, L+4 and L+6, and `mem_req_ready=1` in cycle L+7 (L = `READ_LATENCY`). This stresses the consumer's beat counting.
  - Undefined: beats are back-to-back as specified in Timing.

## Test plan
- Reset release: all outputs are 0 during reset; `mem_req_ready=1` one cycle after release; `mem_resp_valid` stays 0 with no requests.
- Read burst: preload `mem[0x40..0x43]` with A0..A3, then read `addr=0x42`. Required: beats A0, A1, A2, A3 in cycles 4 through 7; `mem_req_ready` high in cycle 8.
- Masked write then read: `mem[0x10]` is all 0x11 bytes. Write `addr=0x10`, data all 0xFF bytes, `mask=16'h000F`. A subsequent read of `0x10` returns `128'h1111...1111_FFFFFFFF` on beat 0.
- Write data delay: hold `data_valid` low for 5 cycles after request acceptance. Required: `data_ready` stays high throughout; no array change until the handshake; `mem_req_valid` pulses during WR_DATA are ignored.
- Reset mid-burst: assert `reset` after beat 1. Required: `mem_resp_valid` drops immediately and beats 2 and 3 never appear. After release, a new read of the same block returns all 4 correct beats.
- `MEM_RESP_GAP_EN` build: the same read as the read-burst scenario produces beats in cycles 4, 6, 8 and 10, and `mem_req_ready` in cycle 11.
